// File: rtl/mmu_pkg.sv
// Types and defaults shared by the memory-port arbiter and the MMU FSM:
// the arbiter state encoding, bus-width defaults and the round-robin pick rule.
package mmu_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IC = 2'd1,
        SERVE_DC = 2'd2,
        RESP     = 2'd3
    } arb_state_e;

    // The data cache wins when it is the only requester, or on a tie when the
    // instruction cache held the last grant.
    function automatic logic rr_pick_dc(input logic ic_req, input logic dc_req,
                                        input logic last_dc);
        return dc_req && (!ic_req || !last_dc);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog for one memory transfer: counts SERVE cycles while run is high.
// Only built with MEM_TIMEOUT_EN defined.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    // Count is 0 in the first SERVE cycle, so the LIMIT-th cycle sees LIMIT-1.
    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign expired = run && (cnt_q == LAST);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving the I-cache and D-cache turns on one memory port.
// Define MEM_TIMEOUT_EN to abort transfers that stay busy for TIMEOUT_CYC cycles.
module mem_port_arbiter
    import mmu_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT_CYC must be within 2..255");
    end

    arb_state_e        state_q, state_d;
    logic              last_dc_q, last_dc_d;
    logic              ic_done_q, ic_done_d;
    logic              dc_done_q, dc_done_d;
    logic              mem_ren_q, mem_ren_d;
    logic              mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              serve_end;
    logic              pick_dc;

`ifdef MEM_TIMEOUT_EN
    logic serving;
    logic timed_out;
    logic rsp_err_q, rsp_err_d;

    assign serving = (state_q == SERVE_IC) || (state_q == SERVE_DC);

    mem_timeout_ctr #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .run    (serving),
        .expired(timed_out)
    );

    // A ready in the expiry cycle still counts as a normal completion.
    assign serve_end = mem_ready || timed_out;
    assign rsp_err   = rsp_err_q;
`else
    assign serve_end = mem_ready;
    assign rsp_err   = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one
        // unassigned; a missing default would infer a latch.
        state_d     = state_q;
        last_dc_d   = last_dc_q;
        pick_dc     = 1'b0;
        ic_done_d   = 1'b0;
        dc_done_d   = 1'b0;
        mem_ren_d   = mem_ren_q;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = '0;
`ifdef MEM_TIMEOUT_EN
        rsp_err_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (ic_req || dc_req) begin
                    pick_dc     = rr_pick_dc(ic_req, dc_req, last_dc_q);
                    last_dc_d   = pick_dc;
                    state_d     = pick_dc ? SERVE_DC : SERVE_IC;
                    mem_addr_d  = pick_dc ? dc_addr : ic_addr;
                    mem_wen_d   = pick_dc && dc_we;
                    mem_ren_d   = !(pick_dc && dc_we);
                    mem_wdata_d = (pick_dc && dc_we) ? dc_wdata : '0;
                end
            end

            SERVE_IC, SERVE_DC: begin
                // Strobe and address stay frozen from grant until the memory answers.
                if (serve_end) begin
                    state_d     = RESP;
                    ic_done_d   = (state_q == SERVE_IC);
                    dc_done_d   = (state_q == SERVE_DC);
                    rsp_rdata_d = (mem_ready && mem_ren_q) ? mem_rdata : '0;
                    mem_ren_d   = 1'b0;
                    mem_wen_d   = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
`ifdef MEM_TIMEOUT_EN
                    rsp_err_d   = !mem_ready;
`endif
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_dc_q   <= 1'b1;
            ic_done_q   <= 1'b0;
            dc_done_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_dc_q   <= last_dc_d;
            ic_done_q   <= ic_done_d;
            dc_done_q   <= dc_done_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef MEM_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign ic_done   = ic_done_q;
    assign dc_done   = dc_done_q;
    assign mem_ren   = mem_ren_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: request rounds from a vector table feed a scoreboard
// of expected completions; a behavioural memory answers after a per-round latency.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        dc_done;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ic_req   (ic_req),
        .ic_addr  (ic_addr),
        .ic_done  (ic_done),
        .dc_req   (dc_req),
        .dc_we    (dc_we),
        .dc_addr  (dc_addr),
        .dc_wdata (dc_wdata),
        .dc_done  (dc_done),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ic;
        bit          dc;
        bit          we;
        logic [31:0] ic_addr;
        logic [31:0] dc_addr;
        logic [31:0] wdata;
        int          lat;
    } vec_t;

    typedef struct {
        bit          is_dc;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          strobes;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   next_start = 0;
    int   strobe_cnt = 0;
    int   mem_lat = 1;
    bit   last_dc_m = 1'b1;
    bit   ic_drop = 1'b0;
    bit   dc_drop = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : {~a[15:0], a[15:0]};
    endfunction

    task automatic push_exp(input bit is_dc, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat);
        exp_t e;
        e.is_dc   = is_dc;
        e.we      = we;
        e.addr    = addr;
        e.wdata   = wdata;
        e.rdata   = we ? 32'h0 : mem_fn(addr);
        e.err     = 1'b0;
        e.strobes = lat;
`ifdef MEM_TIMEOUT_EN
        if (lat > TO) begin
            e.strobes = TO;
            e.err     = 1'b1;
            e.rdata   = 32'h0;
        end
`endif
        sb.push_back(e);
        last_dc_m = is_dc;
    endtask

    // One clock cycle: observe outputs at the falling edge, then update the
    // requesters and the memory model for the next rising edge.
    task automatic step();
        logic strobe;
        exp_t e;
        @(negedge clk);
        cyc++;
        if (ic_drop) begin ic_req = 1'b0; ic_drop = 1'b0; end
        if (dc_drop) begin dc_req = 1'b0; dc_drop = 1'b0; end
        strobe = mem_ren | mem_wen;
        check("ren_wen_exclusive", 64'(mem_ren & mem_wen), 0);
        check("done_exclusive", 64'(ic_done & dc_done), 0);
        if (strobe) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = sb[0];
                if (strobe_cnt == 0) check("grant_cycle", 64'(cyc), 64'(next_start));
                check("mem_addr", mem_addr, e.addr);
                check("mem_wen", 64'(mem_wen), 64'(e.we));
                check("mem_ren", 64'(mem_ren), 64'(!e.we));
                if (e.we) check("mem_wdata", mem_wdata, e.wdata);
            end
            strobe_cnt++;
        end
        if (ic_done || dc_done) begin
            check("strobe_in_resp", 64'(strobe), 0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("done_owner_dc", {ic_done, dc_done}, {!e.is_dc, e.is_dc});
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("strobe_cycles", 64'(strobe_cnt), 64'(e.strobes));
                if (sb.size() != 0) next_start = cyc + 2;
            end
            if (ic_done) ic_drop = 1'b1;
            if (dc_done) dc_drop = 1'b1;
            strobe_cnt = 0;
        end else if (!strobe) begin
            check("idle_outputs", {rsp_rdata, rsp_err, mem_addr[30:0]}, 0);
            check("idle_wdata", mem_wdata, 0);
            strobe_cnt = 0;
        end
        if (strobe && strobe_cnt == mem_lat) begin
            mem_ready = 1'b1;
            mem_rdata = mem_fn(mem_addr);
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'hBAD0_0BAD;
        end
    endtask

    task automatic run_round(input vec_t v);
        bit dc_first;
        ic_req   = v.ic;
        ic_addr  = v.ic_addr;
        dc_req   = v.dc;
        dc_we    = v.we;
        dc_addr  = v.dc_addr;
        dc_wdata = v.wdata;
        mem_lat  = v.lat;
        dc_first = v.dc && (!v.ic || !last_dc_m);
        if (dc_first) begin
            push_exp(1'b1, v.we, v.dc_addr, v.wdata, v.lat);
            if (v.ic) push_exp(1'b0, 1'b0, v.ic_addr, 32'h0, v.lat);
        end else if (v.ic) begin
            push_exp(1'b0, 1'b0, v.ic_addr, 32'h0, v.lat);
            if (v.dc) push_exp(1'b1, v.we, v.dc_addr, v.wdata, v.lat);
        end
        next_start = cyc + 1;
        for (int k = 0; k < 300 && (sb.size() != 0 || ic_req || dc_req); k++) step();
        if (sb.size() != 0 || ic_req || dc_req) begin
            check("round_bound", 1, 0);
            sb.delete();
            ic_req = 1'b0;
            dc_req = 1'b0;
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{ic: 1, dc: 1, we: 0, ic_addr: 32'h140, dc_addr: 32'h240, wdata: 32'h0,         lat: 2};
        vecs[1] = '{ic: 1, dc: 0, we: 0, ic_addr: 32'h100, dc_addr: 32'h0,   wdata: 32'h0,         lat: 3};
        vecs[2] = '{ic: 1, dc: 1, we: 0, ic_addr: 32'h180, dc_addr: 32'h280, wdata: 32'h0,         lat: 1};
        vecs[3] = '{ic: 0, dc: 1, we: 1, ic_addr: 32'h0,   dc_addr: 32'h200, wdata: 32'h1234_5678, lat: 2};
        vecs[4] = '{ic: 1, dc: 1, we: 1, ic_addr: 32'h1C0, dc_addr: 32'h2C0, wdata: 32'hA5A5_5A5A, lat: 4};
        vecs[5] = '{ic: 0, dc: 1, we: 0, ic_addr: 32'h0,   dc_addr: 32'h300, wdata: 32'h0,         lat: 1};
        vecs[6] = '{ic: 1, dc: 1, we: 0, ic_addr: 32'h1E0, dc_addr: 32'h3E0, wdata: 32'h0,         lat: 2};

        reset     = 1'b1;
        ic_req    = 1'b0;
        ic_addr   = 32'h0;
        dc_req    = 1'b0;
        dc_we     = 1'b0;
        dc_addr   = 32'h0;
        dc_wdata  = 32'h0;
        mem_rdata = 32'h0;
        mem_ready = 1'b0;
        repeat (2) step();
        check("reset_strobes_done", {mem_ren, mem_wen, ic_done, dc_done}, 0);
        check("reset_data", {rsp_rdata, mem_wdata}, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_round(vecs[i]);

        // Reset in the middle of a data-cache read: the transfer vanishes.
        dc_req   = 1'b1;
        dc_we    = 1'b0;
        dc_addr  = 32'h3F0;
        mem_lat  = 100;
        push_exp(1'b1, 1'b0, 32'h3F0, 32'h0, 100);
        next_start = cyc + 1;
        repeat (3) step();
        check("serving_before_reset", 64'(mem_ren), 1);
        reset  = 1'b1;
        dc_req = 1'b0;
        step();
        check("reset_abort_strobes", {mem_ren, mem_wen}, 0);
        check("reset_abort_done", {ic_done, dc_done}, 0);
        sb.delete();
        last_dc_m  = 1'b1;
        strobe_cnt = 0;
        reset = 1'b0;
        repeat (4) step();

        // Pointer is back to DC after reset, so the next tie goes to IC.
        run_round(vecs[6]);

`ifdef MEM_TIMEOUT_EN
        run_round('{ic: 0, dc: 1, we: 0, ic_addr: 32'h0,   dc_addr: 32'h340, wdata: 32'h0, lat: 100});
        run_round('{ic: 0, dc: 1, we: 0, ic_addr: 32'h0,   dc_addr: 32'h344, wdata: 32'h0, lat: TO});
        run_round('{ic: 1, dc: 0, we: 0, ic_addr: 32'h148, dc_addr: 32'h0,   wdata: 32'h0, lat: TO + 1});
        run_round('{ic: 0, dc: 1, we: 1, ic_addr: 32'h0,   dc_addr: 32'h348, wdata: 32'h0F0F_F0F0, lat: 100});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
